// File: rtl/pool2_sched.sv
// pool2_sched: layer-2 2x2 max-pool scheduler driving IFM reads, pool strobes, next-layer writes and group handshakes
module pool2_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE = 10,
  parameter int IFM_DEPTH = 16,
  parameter int KERNAL_SIZE = 2,
  parameter int NUMBER_OF_UNITS = 3,
  parameter int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
  parameter int NUM_GROUPS = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int SEL_WIDTH = $clog2(NUM_GROUPS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  output logic                             end_to_previous,
  output logic                             ifm_enable_read_A_current,
  output logic                             ifm_enable_read_B_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_A_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_B_current,
  output logic                             fifo_enable,
  output logic                             pool_enable,
  input  logic                             end_from_next,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             start_to_next,
  output logic [SEL_WIDTH-1:0]             ifm_sel_next
);
  localparam int AW = ADDRESS_SIZE_IFM;
  localparam int NW = ADDRESS_SIZE_NEXT_IFM;
  localparam int LAST = IFM_SIZE_NEXT - 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [NW-1:0] i, j, ni, nj, wa_p;
  logic col, ncol, d, nd, go, last, pending_start, next_free, wr_p;
  logic [AW-1:0] a_nxt;
  logic [SEL_WIDTH-1:0] group;
  assign go = state == IDLE && (pending_start || start_from_previous) && (next_free || end_from_next);
  assign last = i == NW'(LAST) && j == NW'(LAST) && col;
  assign a_nxt = AW'(ni) * AW'(2 * IFM_SIZE) + AW'({nj, 1'b0}) + AW'(ncol);
  assign ifm_enable_read_A_current = state == RUN;
  assign ifm_enable_read_B_current = state == RUN;
  assign start_to_next = state == DONE;
  assign end_to_previous = state == DONE;
  assign ifm_sel_next = group;
  always_comb begin
    state_nxt = state;
    ni = i;
    nj = j;
    ncol = col;
    nd = d;
    case (state)
      IDLE: if (go) begin
        state_nxt = RUN;
        ni = '0;
        nj = '0;
        ncol = 1'b0;
      end
      RUN: begin
        ncol = ~col;
        nd = 1'b0;
        nj = col ? (j == NW'(LAST) ? '0 : j + NW'(1)) : j;
        ni = col && j == NW'(LAST) ? i + NW'(1) : i;
        state_nxt = last ? DRAIN : RUN;
      end
      DRAIN: begin
        nd = ~d;
        state_nxt = d ? DONE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      col <= 1'b0;
      d <= 1'b0;
      group <= '0;
      pending_start <= 1'b0;
      next_free <= 1'b1;
      ifm_address_read_A_current <= '0;
      ifm_address_read_B_current <= '0;
      fifo_enable <= 1'b0;
      pool_enable <= 1'b0;
      wr_p <= 1'b0;
      wa_p <= '0;
      ifm_enable_write_next <= 1'b0;
      ifm_address_write_next <= '0;
    end else begin
      state <= state_nxt;
      i <= ni;
      j <= nj;
      col <= ncol;
      d <= nd;
      group <= state == DONE ? (group == SEL_WIDTH'(NUM_GROUPS - 1) ? '0 : group + SEL_WIDTH'(1)) : group;
      pending_start <= go ? pending_start && start_from_previous : pending_start || start_from_previous;
      next_free <= end_from_next || (next_free && state != DONE);
      if (state_nxt == RUN) begin
        ifm_address_read_A_current <= a_nxt;
        ifm_address_read_B_current <= a_nxt + AW'(IFM_SIZE);
      end
      fifo_enable <= state == RUN && !col;
      pool_enable <= state == RUN && col;
      wr_p <= state == RUN && col;
      if (state == RUN && col) wa_p <= i * NW'(IFM_SIZE_NEXT) + j;
      ifm_enable_write_next <= wr_p;
      if (wr_p) ifm_address_write_next <= wa_p;
    end
  end
endmodule

// File: tb/tb_pool2_sched.sv
// tb_pool2_sched: directed scenario tests for the layer-2 pool scheduler
module tb_pool2_sched;
  logic clk = 1'b0, reset = 1'b1, start_from_previous = 1'b0, end_from_next = 1'b0;
  logic end_to_previous, en_a, en_b, fifo_enable, pool_enable, wr, start_to_next;
  logic [6:0] addr_a, addr_b;
  logic [4:0] waddr;
  logic [2:0] sel;
  int checks = 0, errors = 0, stn_cnt = 0;
  int wq[$];
  pool2_sched dut (
    .clk(clk),
    .reset(reset),
    .start_from_previous(start_from_previous),
    .end_to_previous(end_to_previous),
    .ifm_enable_read_A_current(en_a),
    .ifm_enable_read_B_current(en_b),
    .ifm_address_read_A_current(addr_a),
    .ifm_address_read_B_current(addr_b),
    .fifo_enable(fifo_enable),
    .pool_enable(pool_enable),
    .end_from_next(end_from_next),
    .ifm_enable_write_next(wr),
    .ifm_address_write_next(waddr),
    .start_to_next(start_to_next),
    .ifm_sel_next(sel)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!reset) begin
    if (wr) wq.push_back(int'(waddr));
    if (start_to_next) stn_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!start_to_next && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({en_a, en_b, addr_a, addr_b, fifo_enable, pool_enable, wr, waddr, start_to_next, end_to_previous, sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {en_a, en_b, addr_a, addr_b, fifo_enable, pool_enable, wr, waddr, start_to_next, end_to_previous, sel});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (en_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got en_a=%b want 0", en_a);
    end
  endtask
  task automatic test_first_group();
    int cnt = 1, k = 0, p, ea;
    logic prev_rd = 1'b0, prev_col = 1'b0;
    wq.delete();
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    while (!start_to_next && cnt < 200) begin
      checks++;
      if (fifo_enable !== (prev_rd && !prev_col)) begin
        errors++;
        $display("FAIL fifo_enable cycle %0d got %b want %b", cnt, fifo_enable, prev_rd && !prev_col);
      end
      checks++;
      if (pool_enable !== (prev_rd && prev_col)) begin
        errors++;
        $display("FAIL pool_enable cycle %0d got %b want %b", cnt, pool_enable, prev_rd && prev_col);
      end
      prev_rd = en_a;
      if (en_a) begin
        p = k / 2;
        ea = 20 * (p / 5) + 2 * (p % 5) + k % 2;
        checks++;
        if (int'(addr_a) !== ea || int'(addr_b) !== ea + 10 || en_b !== 1'b1) begin
          errors++;
          $display("FAIL read_%0d got A=%0d B=%0d enB=%b want A=%0d B=%0d enB=1", k, addr_a, addr_b, en_b, ea, ea + 10);
        end
        prev_col = (k % 2) == 1;
        k++;
      end
      tick();
      cnt++;
    end
    checks++;
    if (start_to_next !== 1'b1 || cnt !== 53) begin
      errors++;
      $display("FAIL done_latency got stn=%b cycles=%0d want stn=1 cycles=53", start_to_next, cnt);
    end
    checks++;
    if (end_to_previous !== 1'b1 || sel !== 3'd0) begin
      errors++;
      $display("FAIL done_outputs got etp=%b sel=%0d want etp=1 sel=0", end_to_previous, sel);
    end
    checks++;
    if (k !== 50) begin
      errors++;
      $display("FAIL read_count got %0d want 50", k);
    end
    checks++;
    if (wq.size() !== 25) begin
      errors++;
      $display("FAIL write_count got %0d want 25", wq.size());
    end
    for (int n = 0; n < wq.size() && n < 25; n++) begin
      checks++;
      if (wq[n] !== n) begin
        errors++;
        $display("FAIL write_addr_%0d got %0d want %0d", n, wq[n], n);
      end
    end
    tick();
    checks++;
    if (start_to_next !== 1'b0 || sel !== 3'd1 || en_a !== 1'b0 || addr_a !== 7'd89 || addr_b !== 7'd99) begin
      errors++;
      $display("FAIL after_done got stn=%b sel=%0d en=%b A=%0d B=%0d want 0 1 0 89 99", start_to_next, sel, en_a, addr_a, addr_b);
    end
    checks++;
    if (stn_cnt !== 1) begin
      errors++;
      $display("FAIL stn_pulses got %0d want 1", stn_cnt);
    end
  endtask
  task automatic test_blocked();
    int n;
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    repeat (5) tick();
    checks++;
    if (en_a !== 1'b0 || en_b !== 1'b0) begin
      errors++;
      $display("FAIL blocked_idle got en=%b%b want 00", en_a, en_b);
    end
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    checks++;
    if (en_a !== 1'b1 || addr_a !== 7'd0 || sel !== 3'd1) begin
      errors++;
      $display("FAIL released_run got en=%b A=%0d sel=%0d want 1 0 1", en_a, addr_a, sel);
    end
    wait_done(n);
    checks++;
    if (n !== 52 || sel !== 3'd1) begin
      errors++;
      $display("FAIL group1_done got cycles=%0d sel=%0d want 52 1", n, sel);
    end
    tick();
  endtask
  task automatic test_mid_run_start();
    int n;
    end_from_next = 1'b1;
    start_from_previous = 1'b1;
    tick();
    end_from_next = 1'b0;
    start_from_previous = 1'b0;
    checks++;
    if (en_a !== 1'b1 || sel !== 3'd2) begin
      errors++;
      $display("FAIL group2_run got en=%b sel=%0d want 1 2", en_a, sel);
    end
    repeat (10) tick();
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    checks++;
    if (addr_a !== 7'd21 || addr_b !== 7'd31 || en_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_addr got A=%0d B=%0d en=%b want 21 31 1", addr_a, addr_b, en_a);
    end
    wait_done(n);
    checks++;
    if (n !== 41) begin
      errors++;
      $display("FAIL mid_run_done got cycles=%0d want 41", n);
    end
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    checks++;
    if (en_a !== 1'b0 || sel !== 3'd3) begin
      errors++;
      $display("FAIL post_done_idle got en=%b sel=%0d want 0 3", en_a, sel);
    end
    tick();
    checks++;
    if (en_a !== 1'b1 || addr_a !== 7'd0) begin
      errors++;
      $display("FAIL pending_restart got en=%b A=%0d want 1 0", en_a, addr_a);
    end
  endtask
  task automatic test_group_wrap();
    int n;
    for (int g = 3; g < 6; g++) begin
      wait_done(n);
      checks++;
      if (start_to_next !== 1'b1 || sel !== 3'(g)) begin
        errors++;
        $display("FAIL wrap_done_%0d got stn=%b sel=%0d want 1 %0d", g, start_to_next, sel, g);
      end
      tick();
      checks++;
      if (sel !== 3'((g + 1) % 6)) begin
        errors++;
        $display("FAIL wrap_sel_%0d got %0d want %0d", g, sel, (g + 1) % 6);
      end
      end_from_next = 1'b1;
      start_from_previous = 1'b1;
      tick();
      end_from_next = 1'b0;
      start_from_previous = 1'b0;
      checks++;
      if (en_a !== 1'b1) begin
        errors++;
        $display("FAIL wrap_run_%0d got en=%b want 1", g, en_a);
      end
    end
  endtask
  task automatic test_reset_mid_run();
    int base;
    repeat (10) tick();
    base = stn_cnt;
    reset = 1'b1;
    tick();
    checks++;
    if ({en_a, en_b, addr_a, addr_b, fifo_enable, pool_enable, wr, waddr, start_to_next, end_to_previous, sel} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got %h want 0", {en_a, en_b, addr_a, addr_b, fifo_enable, pool_enable, wr, waddr, start_to_next, end_to_previous, sel});
    end
    reset = 1'b0;
    repeat (60) tick();
    checks++;
    if (stn_cnt !== base || en_a !== 1'b0) begin
      errors++;
      $display("FAIL no_pulse_after_reset got pulses=%0d en=%b want %0d 0", stn_cnt, en_a, base);
    end
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    checks++;
    if (en_a !== 1'b1 || sel !== 3'd0 || addr_a !== 7'd0 || addr_b !== 7'd10) begin
      errors++;
      $display("FAIL restart_after_reset got en=%b sel=%0d A=%0d B=%0d want 1 0 0 10", en_a, sel, addr_a, addr_b);
    end
  endtask
  initial begin
    test_reset();
    test_first_group();
    test_blocked();
    test_mid_run_start();
    test_group_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
